// File: rtl/dec_to_bin_entry_pkg.sv
// Shared definitions for the decimal-entry front end: FSM encodings,
// the largest legal BCD digit and the width of the unbounded conversion.
package dec_to_bin_entry_pkg;

    // State encoding doubles as the count of digits held
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } entry_state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Two BCD digits never exceed 99, which fits in 7 bits
    localparam int VAL_W = 7;

endpackage

// File: rtl/dec_to_bin_entry_bcd2_to_bin.sv
// Combinational two-digit BCD to binary: tens*10 + ones using shifts and adds.
module bcd2_to_bin
    import dec_to_bin_entry_pkg::*;
(
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic [VAL_W-1:0] val
);

    logic [VAL_W-1:0] tens_w;
    logic [VAL_W-1:0] ones_w;

    assign tens_w = {3'b000, tens};
    assign ones_w = {3'b000, ones};

    // tens*8 + tens*2 + ones
    assign val = (tens_w << 3) + (tens_w << 1) + ones_w;

endmodule

// File: rtl/dec_to_bin_entry.sv
// Decimal-entry front end: collects up to two BCD key strokes, shows them on
// the display digit registers and converts them to binary on enter.
// Priority within a cycle is clear > enter > digit; lower strobes are dropped.
module dec_to_bin_entry
    import dec_to_bin_entry_pkg::*;
#(
    parameter int BIN_W   = 5,
    parameter int MAX_VAL = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       digit_in,
    input  logic             digit_vld,
    input  logic             enter,
    input  logic             clear,
    output logic [3:0]       digit1,
    output logic [3:0]       digit0,
    output logic [1:0]       cnt,
    output logic [BIN_W-1:0] bin,
    output logic             bin_vld,
    output logic             err
);

    localparam logic [VAL_W-1:0] MAX_VAL_W = VAL_W'(MAX_VAL);

    entry_state_t     state_q, state_d;
    logic [3:0]       digit1_d, digit0_d;
    logic [BIN_W-1:0] bin_d;
    logic             bin_vld_d, err_d;
    logic [VAL_W-1:0] val;

    bcd2_to_bin u_conv (
        .tens (digit1),
        .ones (digit0),
        .val  (val)
    );

    assign cnt = state_q;

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_d   = state_q;
        digit1_d  = digit1;
        digit0_d  = digit0;
        bin_d     = bin;
        bin_vld_d = 1'b0;
        err_d     = 1'b0;
        if (clear) begin
            state_d  = S_EMPTY;
            digit1_d = 4'd0;
            digit0_d = 4'd0;
        end else if (enter) begin
            if (state_q == S_EMPTY) begin
                err_d = 1'b1;
            end else begin
                if (val <= MAX_VAL_W) begin
                    bin_d     = BIN_W'(val);
                    bin_vld_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d  = S_EMPTY;
                digit1_d = 4'd0;
                digit0_d = 4'd0;
            end
        end else if (digit_vld) begin
            if (digit_in > DIGIT_MAX) begin
                err_d = 1'b1;
            end else begin
                case (state_q)
                    S_ONE, S_TWO: begin
                        digit1_d = digit0;
                        digit0_d = digit_in;
                        state_d  = S_TWO;
                    end
                    default: begin
                        digit1_d = 4'd0;
                        digit0_d = digit_in;
                        state_d  = S_ONE;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset discards any partial entry and bin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            digit1  <= 4'd0;
            digit0  <= 4'd0;
            bin     <= '0;
            bin_vld <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            digit1  <= digit1_d;
            digit0  <= digit0_d;
            bin     <= bin_d;
            bin_vld <= bin_vld_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_dec_to_bin_entry.sv
// Directed bench for dec_to_bin_entry with hand-computed expected values.
module tb_dec_to_bin_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit_in = 4'd0;
    logic       digit_vld = 1'b0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] digit1, digit0;
    logic [1:0] cnt;
    logic [4:0] bin;
    logic       bin_vld, err;

    int n_tests = 0;
    int n_fail  = 0;

    dec_to_bin_entry #(.BIN_W(5), .MAX_VAL(31)) dut (
        .clk       (clk),
        .rst       (rst),
        .digit_in  (digit_in),
        .digit_vld (digit_vld),
        .enter     (enter),
        .clear     (clear),
        .digit1    (digit1),
        .digit0    (digit0),
        .cnt       (cnt),
        .bin       (bin),
        .bin_vld   (bin_vld),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of strobes, then look at the registered result
    task automatic step(input logic dv, input logic [3:0] din, input logic en, input logic clr);
        @(negedge clk);
        digit_vld = dv;
        digit_in  = din;
        enter     = en;
        clear     = clr;
        @(posedge clk);
        #1;
        digit_vld = 1'b0;
        enter     = 1'b0;
        clear     = 1'b0;
        digit_in  = 4'd0;
    endtask

    task automatic key(input logic [3:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e1, input logic [3:0] e0,
                           input logic [1:0] ec, input logic [4:0] eb,
                           input logic ev, input logic ee);
        chk({tag, ".digit1"}, 32'(digit1), 32'(e1));
        chk({tag, ".digit0"}, 32'(digit0), 32'(e0));
        chk({tag, ".cnt"}, 32'(cnt), 32'(ec));
        chk({tag, ".bin"}, 32'(bin), 32'(eb));
        chk({tag, ".bin_vld"}, 32'(bin_vld), 32'(ev));
        chk({tag, ".err"}, 32'(err), 32'(ee));
    endtask

    initial begin
        // 1. reset
        repeat (3) @(posedge clk);
        #1;
        chk_all("rst_held", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk_all("rst_rel", 0, 0, 0, 0, 0, 0);

        // 2. 2,7 enter -> 27
        key(4'd2);
        chk_all("d2", 0, 2, 1, 0, 0, 0);
        key(4'd7);
        chk_all("d27", 2, 7, 2, 0, 0, 0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk_all("ent27", 0, 0, 0, 27, 1, 0);
        idle();
        chk_all("ent27_after", 0, 0, 0, 27, 0, 0);

        // 3. 5 enter -> 5; empty enter -> err
        key(4'd5);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk_all("ent5", 0, 0, 0, 5, 1, 0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk_all("ent_empty", 0, 0, 0, 5, 0, 1);
        idle();
        chk_all("ent_empty_after", 0, 0, 0, 5, 0, 0);

        // 4. overflow 42 and illegal digit
        key(4'd4);
        key(4'd2);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk_all("ent42", 0, 0, 0, 5, 0, 1);
        key(4'd3);
        key(4'hC);
        chk_all("dig_c", 0, 3, 1, 5, 0, 1);
        idle();
        chk_all("dig_c_after", 0, 3, 1, 5, 0, 0);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk_all("clr_quiet", 0, 0, 0, 5, 0, 0);

        // boundary: 31 accepted, 32 rejected
        key(4'd3);
        key(4'd1);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk_all("ent31", 0, 0, 0, 31, 1, 0);
        key(4'd3);
        key(4'd2);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk_all("ent32", 0, 0, 0, 31, 0, 1);

        // 5. shift 1,2,3 -> 2/3, enter -> 23
        key(4'd1);
        key(4'd2);
        key(4'd3);
        chk_all("d123", 2, 3, 2, 31, 0, 0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk_all("ent23", 0, 0, 0, 23, 1, 0);
        key(4'd3);
        key(4'd1);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        chk_all("clr_ent", 0, 0, 0, 23, 0, 0);

        // enter wins over a simultaneous digit; single digit 9
        key(4'd9);
        step(1'b1, 4'd5, 1'b1, 1'b0);
        chk_all("ent_dig", 0, 0, 0, 9, 1, 0);

        // 6. async reset mid-entry
        key(4'd6);
        chk_all("d6", 0, 6, 1, 9, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk_all("post_rst", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
